mem_handshake_responder: RTL

Multi-cycle memory responder sitting on the far side of the core's memory strobes (read/write, address, write data). It accepts one request at a time, models a fixed access latency with a countdown, performs the word access, and signals completion with a one-cycle `ready` pulse plus an error flag for illegal addresses. It pairs with the multi-cycle control FSM as the memory that control unit's fetch, load and store states talk to.

---
 rtl/mem_handshake_responder.sv | 102 ++++++++++
 1 files changed

// File: rtl/mem_handshake_responder.sv
// Multi-cycle word memory responder: accepts one request at a time, waits
// a fixed latency, performs the access and pulses ready (with err if illegal).
module mem_handshake_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [3:0]    cnt;
   logic [3:0]    cnt_nxt;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic          wr_q;
   logic          ill_q;
   logic          accept;
   logic          access;
   logic          illegal;

   logic [31:0] mem [DEPTH_WORDS];

   assign illegal = (addr[1:0] != 2'b00)
                  | ({2'b00, addr[31:2]} >= DEPTH_L)
                  | (req_read & req_write);

   assign accept = (state == IDLE) & (req_read | req_write);
   assign access = (state == BUSY) & (cnt == 4'd0);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = BUSY;
               cnt_nxt   = CNT_LOAD;
            end
         end
         BUSY: begin
            if (cnt == 4'd0) state_nxt = DONE;
            else             cnt_nxt   = cnt - 4'd1;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         rdata <= 32'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (access) begin
            if (ill_q)      rdata <= 32'd0;
            else if (!wr_q) rdata <= mem[idx_q];
         end
      end
   end

   // Request fields are captured once so the requester may move on early.
   always_ff @(posedge clk) begin
      if (!reset && accept) begin
         idx_q   <= addr[AW+1:2];
         wdata_q <= wdata;
         wr_q    <= req_write;
         ill_q   <= illegal;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && access && wr_q && !ill_q) mem[idx_q] <= wdata_q;
   end

   assign ready = (state == DONE);
   assign err   = (state == DONE) & ill_q;
   assign busy  = (state != IDLE);

endmodule
